// File: rtl/preempt_context.sv
// rtl/preempt_context.sv - round-robin process context table with preemption/HALT/SYSCALL save and kernel RETURN dispatch.
// Optional build macro CTX_STATS_EN adds the preempt_total saturating counter output.
module preempt_context #(
  parameter int                      ADDRESS_SIZE = 32,
  parameter int                      NUM_PROC     = 4,
  parameter int                      PID_W        = 2,
  parameter int                      KERNEL_PID   = 0,
  parameter logic [ADDRESS_SIZE-1:0] KERNEL_ENTRY = 'd18,
  parameter int                      PC_STEP      = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    intr,
  input  logic [31:0]             inst,
  input  logic [ADDRESS_SIZE-1:0] PCout,
  input  logic                    proc_load,
  input  logic [PID_W-1:0]        proc_load_pid,
  input  logic [ADDRESS_SIZE-1:0] proc_load_pc,
  output logic [ADDRESS_SIZE-1:0] ret_pc,
  output logic                    ret_valid,
  output logic [PID_W-1:0]        cur_pid,
  output logic                    in_kernel,
  output logic [NUM_PROC-1:0]     ready_mask,
`ifdef CTX_STATS_EN
  output logic [15:0]             preempt_total,
`endif
  output logic [ADDRESS_SIZE-1:0] saved_pc
);

  localparam logic [5:0]       OP_RETURN  = 6'b101100;
  localparam logic [5:0]       OP_HALT    = 6'b111111;
  localparam logic [5:0]       OP_SYSCALL = 6'b101101;
  localparam logic [PID_W-1:0] KPID       = PID_W'(KERNEL_PID);

  typedef enum logic {S_KERNEL, S_USER} state_t;

  state_t                  state_q, state_d;
  logic [ADDRESS_SIZE-1:0] pc_tab_q [NUM_PROC];
  logic [ADDRESS_SIZE-1:0] pc_tab_d [NUM_PROC];
  logic [NUM_PROC-1:0]     ready_q, ready_d;
  logic [PID_W-1:0]        cur_pid_q, cur_pid_d;
  logic [PID_W-1:0]        last_pid_q, last_pid_d;
  logic [ADDRESS_SIZE-1:0] ret_pc_q, ret_pc_d;
  logic                    ret_valid_q, ret_valid_d;
  logic [ADDRESS_SIZE-1:0] saved_pc_q, saved_pc_d;
`ifdef CTX_STATS_EN
  logic [15:0]             preempt_total_q, preempt_total_d;
`endif

  logic [5:0]              opcode;
  logic                    is_return, is_halt, is_syscall;
  logic                    found;
  logic [PID_W-1:0]        next_pid;
  logic [PID_W-1:0]        cand;
  logic [ADDRESS_SIZE-1:0] sys_pc;
  logic                    unused_inst_bits;

  assign opcode           = inst[31:26];
  assign is_return        = (opcode == OP_RETURN);
  assign is_halt          = (opcode == OP_HALT);
  assign is_syscall       = (opcode == OP_SYSCALL);
  assign sys_pc           = PCout + ADDRESS_SIZE'(PC_STEP);
  assign unused_inst_bits = ^inst[25:0];

  // First ready non-kernel slot after last_pid, wrapping around the table.
  always_comb begin
    found    = 1'b0;
    next_pid = KPID;
    cand     = '0;
    for (int k = 1; k <= NUM_PROC; k++) begin
      cand = last_pid_q + PID_W'(k);
      if (!found && (cand != KPID) && ready_q[cand]) begin
        found    = 1'b1;
        next_pid = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_tab_d    = pc_tab_q;
    ready_d     = ready_q;
    cur_pid_d   = cur_pid_q;
    last_pid_d  = last_pid_q;
    ret_pc_d    = ret_pc_q;
    ret_valid_d = 1'b0;
    saved_pc_d  = saved_pc_q;
`ifdef CTX_STATS_EN
    preempt_total_d = preempt_total_q;
`endif

    if (proc_load && (proc_load_pid != KPID)) begin
      pc_tab_d[proc_load_pid] = proc_load_pc;
      ready_d[proc_load_pid]  = 1'b1;
    end

    // Save events are applied after proc_load so they win on a shared slot.
    case (state_q)
      S_KERNEL: begin
        if (is_return && found) begin
          ret_pc_d    = pc_tab_q[next_pid];
          ret_valid_d = 1'b1;
          cur_pid_d   = next_pid;
          state_d     = S_USER;
        end
      end
      S_USER: begin
        if (intr) begin
          pc_tab_d[cur_pid_q] = PCout;
          saved_pc_d          = PCout;
          last_pid_d          = cur_pid_q;
          cur_pid_d           = KPID;
          state_d             = S_KERNEL;
`ifdef CTX_STATS_EN
          if (preempt_total_q != 16'hFFFF) preempt_total_d = preempt_total_q + 16'd1;
`endif
        end else if (is_halt) begin
          ready_d[cur_pid_q] = 1'b0;
          saved_pc_d         = PCout;
          last_pid_d         = cur_pid_q;
          cur_pid_d          = KPID;
          ret_pc_d           = KERNEL_ENTRY;
          ret_valid_d        = 1'b1;
          state_d            = S_KERNEL;
        end else if (is_syscall) begin
          pc_tab_d[cur_pid_q] = sys_pc;
          saved_pc_d          = sys_pc;
          last_pid_d          = cur_pid_q;
          cur_pid_d           = KPID;
          ret_pc_d            = KERNEL_ENTRY;
          ret_valid_d         = 1'b1;
          state_d             = S_KERNEL;
        end
      end
      default: state_d = S_KERNEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_KERNEL;
      for (int i = 0; i < NUM_PROC; i++) pc_tab_q[i] <= '0;
      ready_q     <= '0;
      cur_pid_q   <= KPID;
      last_pid_q  <= KPID;
      ret_pc_q    <= '0;
      ret_valid_q <= 1'b0;
      saved_pc_q  <= '0;
`ifdef CTX_STATS_EN
      preempt_total_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pc_tab_q    <= pc_tab_d;
      ready_q     <= ready_d;
      cur_pid_q   <= cur_pid_d;
      last_pid_q  <= last_pid_d;
      ret_pc_q    <= ret_pc_d;
      ret_valid_q <= ret_valid_d;
      saved_pc_q  <= saved_pc_d;
`ifdef CTX_STATS_EN
      preempt_total_q <= preempt_total_d;
`endif
    end
  end

  assign ret_pc     = ret_pc_q;
  assign ret_valid  = ret_valid_q;
  assign cur_pid    = cur_pid_q;
  assign in_kernel  = (state_q == S_KERNEL);
  assign ready_mask = ready_q;
  assign saved_pc   = saved_pc_q;
`ifdef CTX_STATS_EN
  assign preempt_total = preempt_total_q;
`endif

endmodule

// File: tb/tb_preempt_context.sv
// tb/tb_preempt_context.sv - scoreboard bench for preempt_context: queued ret_valid events plus directed status checks.
module tb_preempt_context;

  localparam logic [31:0] I_NOP = 32'h0;
  localparam logic [31:0] I_RET = {6'b101100, 26'd0};
  localparam logic [31:0] I_HLT = {6'b111111, 26'd0};
  localparam logic [31:0] I_SYS = {6'b101101, 26'd0};

  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  pid;
  } ret_t;

  logic        clk, reset, intr, proc_load;
  logic [31:0] inst, PCout, proc_load_pc, ret_pc, saved_pc;
  logic [1:0]  proc_load_pid, cur_pid;
  logic        ret_valid, in_kernel;
  logic [3:0]  ready_mask;
`ifdef CTX_STATS_EN
  logic [15:0] preempt_total;
`endif

  int   checks = 0;
  int   errors = 0;
  ret_t exp_q[$];

  preempt_context dut (
    .clk(clk), .reset(reset), .intr(intr), .inst(inst), .PCout(PCout),
    .proc_load(proc_load), .proc_load_pid(proc_load_pid), .proc_load_pc(proc_load_pc),
    .ret_pc(ret_pc), .ret_valid(ret_valid), .cur_pid(cur_pid), .in_kernel(in_kernel),
    .ready_mask(ready_mask),
`ifdef CTX_STATS_EN
    .preempt_total(preempt_total),
`endif
    .saved_pc(saved_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    intr = 1'b0; inst = I_NOP; PCout = '0;
    proc_load = 1'b0; proc_load_pid = '0; proc_load_pc = '0;
  endtask

  task automatic op(input logic i, input logic [31:0] in, input logic [31:0] pc);
    intr = i; inst = in; PCout = pc;
    tick();
    idle();
  endtask

  task automatic load(input logic [1:0] pid, input logic [31:0] pc);
    proc_load = 1'b1; proc_load_pid = pid; proc_load_pc = pc;
    tick();
    idle();
  endtask

  task automatic expect_ret(input logic [31:0] pc, input logic [1:0] pid);
    ret_t e;
    e.pc = pc; e.pid = pid;
    exp_q.push_back(e);
  endtask

  // Monitor: every ret_valid strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (ret_valid === 1'b1) begin
      ret_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ret: ret_valid high with ret_pc=0x%0h cur_pid=%0d, none expected", ret_pc, cur_pid);
      end else begin
        e = exp_q.pop_front();
        chk("ret_pc", ret_pc, e.pc);
        chk("ret_pid", {30'd0, cur_pid}, {30'd0, e.pid});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    chk("rst_cur_pid", {30'd0, cur_pid}, 32'd0);
    chk("rst_in_kernel", {31'd0, in_kernel}, 32'd1);
    chk("rst_ready", {28'd0, ready_mask}, 32'd0);
    chk("rst_ret_valid", {31'd0, ret_valid}, 32'd0);
    chk("rst_ret_pc", ret_pc, 32'd0);
    chk("rst_saved_pc", saved_pc, 32'd0);

    op(1'b0, I_RET, 32'd0);
    chk("empty_ret_valid", {31'd0, ret_valid}, 32'd0);
    chk("empty_cur_pid", {30'd0, cur_pid}, 32'd0);
    chk("empty_in_kernel", {31'd0, in_kernel}, 32'd1);

    load(2'd0, 32'h55);
    chk("kpid_load_ignored", {28'd0, ready_mask}, 32'd0);
    load(2'd1, 32'h40);
    load(2'd2, 32'h80);
    chk("load_ready", {28'd0, ready_mask}, 32'b0110);

    op(1'b1, I_NOP, 32'h11);
    chk("kernel_intr_saved", saved_pc, 32'd0);
    chk("kernel_intr_pid", {30'd0, cur_pid}, 32'd0);

    expect_ret(32'h40, 2'd1);
    op(1'b0, I_RET, 32'd0);
    chk("ret1_in_kernel", {31'd0, in_kernel}, 32'd0);

    op(1'b0, I_RET, 32'h41);
    chk("user_ret_noop", {30'd0, cur_pid}, 32'd1);

    op(1'b1, I_NOP, 32'h47);
    chk("intr_saved_pc", saved_pc, 32'h47);
    chk("intr_cur_pid", {30'd0, cur_pid}, 32'd0);
    chk("intr_in_kernel", {31'd0, in_kernel}, 32'd1);
    chk("intr_no_ret", {31'd0, ret_valid}, 32'd0);

    expect_ret(32'h80, 2'd2);
    op(1'b0, I_RET, 32'd0);

    expect_ret(32'd18, 2'd0);
    op(1'b0, I_SYS, 32'h85);
    chk("sys_saved_pc", saved_pc, 32'h86);
    chk("sys_ready", {28'd0, ready_mask}, 32'b0110);

    expect_ret(32'h47, 2'd1);
    op(1'b0, I_RET, 32'd0);

    op(1'b1, I_HLT, 32'h50);
    chk("halt_intr_ready", {28'd0, ready_mask}, 32'b0110);
    chk("halt_intr_saved", saved_pc, 32'h50);
    chk("halt_intr_no_ret", {31'd0, ret_valid}, 32'd0);

    expect_ret(32'h86, 2'd2);
    op(1'b0, I_RET, 32'd0);
    op(1'b1, I_NOP, 32'h90);
    expect_ret(32'h50, 2'd1);
    op(1'b0, I_RET, 32'd0);

    expect_ret(32'd18, 2'd0);
    op(1'b0, I_HLT, 32'h51);
    chk("halt_ready", {28'd0, ready_mask}, 32'b0100);
    chk("halt_saved", saved_pc, 32'h51);
    chk("halt_in_kernel", {31'd0, in_kernel}, 32'd1);

    load(2'd1, 32'h30);
    expect_ret(32'h90, 2'd2);
    op(1'b0, I_RET, 32'd0);
    op(1'b1, I_NOP, 32'h91);
    expect_ret(32'h30, 2'd1);
    op(1'b0, I_RET, 32'd0);

    proc_load = 1'b1; proc_load_pid = 2'd1; proc_load_pc = 32'h99;
    op(1'b1, I_NOP, 32'h60);
    chk("collide_saved", saved_pc, 32'h60);
    expect_ret(32'h91, 2'd2);
    op(1'b0, I_RET, 32'd0);
    op(1'b1, I_NOP, 32'h92);
    expect_ret(32'h60, 2'd1);
    op(1'b0, I_RET, 32'd0);
    op(1'b1, I_NOP, 32'h61);

    reset = 1'b1;
    op(1'b0, I_RET, 32'd0);
    reset = 1'b0;
    chk("midrst_ret_valid", {31'd0, ret_valid}, 32'd0);
    chk("midrst_ready", {28'd0, ready_mask}, 32'd0);
    chk("midrst_saved", saved_pc, 32'd0);
    for (int i = 0; i < 4; i++) chk($sformatf("midrst_tab%0d", i), dut.pc_tab_q[i], 32'd0);

    load(2'd3, 32'h10);
    expect_ret(32'h10, 2'd3);
    op(1'b0, I_RET, 32'd0);
    expect_ret(32'd18, 2'd0);
    op(1'b0, I_SYS, 32'hFFFF_FFFF);
    chk("sys_wrap_saved", saved_pc, 32'd0);
    expect_ret(32'd0, 2'd3);
    op(1'b0, I_RET, 32'd0);

`ifdef CTX_STATS_EN
    chk("preempt_total", {16'd0, preempt_total}, 32'd0);
`endif

    tick(); tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/preempt_context.md
Name: preempt_context

Overview:
- Downstream consumer of the quantum interruptor's `intr` pulse and issued instruction (`inst_out`).
- Keeps a small round-robin process table of saved PCs and tracks the current PID and kernel/user mode.
- Saves the displaced PC on preemption, HALT and SYSCALL.
- On kernel RETURN, supplies the next ready process's PC to the PC-source mux.

Parameters:
- ADDRESS_SIZE, 32, PC/instruction width
- NUM_PROC, 4, process table slots (power of two)
- PID_W, 2, log2(NUM_PROC)
- KERNEL_PID, 0, slot reserved for kernel; never scheduled
- KERNEL_ENTRY, 32'd18, kernel dispatcher address (same target as the preemption jump)
- PC_STEP, 1, PC increment per instruction

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- intr  in  1  preemption pulse from interruptor (one cycle)
- inst  in  32  instruction issued this cycle (interruptor inst_out); opcode = inst[31:26]
- PCout  in  ADDRESS_SIZE  PC of the instruction in `inst`
- proc_load  in  1  kernel write strobe for a table entry
- proc_load_pid  in  PID_W  slot to write
- proc_load_pc  in  ADDRESS_SIZE  start/resume PC to write
- ret_pc  out  ADDRESS_SIZE  redirect target
- ret_valid  out  1  one-cycle strobe: PC mux must take ret_pc
- cur_pid  out  PID_W  running process
- in_kernel  out  1  1 while in KERNEL state
- ready_mask  out  NUM_PROC  per-slot ready bits
- saved_pc  out  ADDRESS_SIZE  last PC written by a save event (kernel readback)

Behaviour:
- Opcodes decoded: RETURN 6'b101100, HALT 6'b111111, SYSCALL 6'b101101.
- Reset, synchronous and priority over everything:
  - state=KERNEL, cur_pid=KERNEL_PID, last_pid=KERNEL_PID.
  - all table PCs=0, ready_mask=0.
  - ret_pc=0, ret_valid=0, saved_pc=0, in_kernel=1.
- All outputs are registered; ret_valid is high exactly one cycle after the triggering edge, else 0.
- proc_load:
  - Accepted in any state: table[pid]<=proc_load_pc, ready[pid]<=1.
  - Ignored when pid==KERNEL_PID.
  - Same-cycle save event to the same slot wins over proc_load.
- KERNEL state:
  - intr ignored.
  - On RETURN, search slots last_pid+1 … last_pid+NUM_PROC (mod NUM_PROC), skipping KERNEL_PID; pick the first ready slot.
  - Slot found: ret_pc<=table[next], ret_valid<=1, cur_pid<=next, state<=USER, in_kernel<=0.
  - No slot found: RETURN is a no-op, ret_valid=0, stay KERNEL.
- USER state, priority intr > HALT > SYSCALL:
  - intr: table[cur]<=PCout, saved_pc<=PCout, last_pid<=cur, cur_pid<=KERNEL_PID, state<=KERNEL. No ret_valid, because the interruptor's jump already redirects. PCout here is the displaced instruction, which did not execute.
  - HALT: ready[cur]<=0, saved_pc<=PCout, last_pid<=cur, cur_pid<=KERNEL_PID, ret_pc<=KERNEL_ENTRY, ret_valid<=1, state<=KERNEL.
  - SYSCALL: table[cur]<=PCout+PC_STEP (modulo 2^ADDRESS_SIZE), saved_pc<=same value, ready kept, last_pid<=cur, cur_pid<=KERNEL_PID, ret_pc<=KERNEL_ENTRY, ret_valid<=1, state<=KERNEL.
  - RETURN in USER: no-op.
- Round-robin search is combinational over ready_mask and last_pid; single-cycle decision.
- Reset mid-operation (including the cycle ret_valid would fire): ret_valid=0 next cycle, table cleared.

Optional Feature:
- Macro: CTX_STATS_EN.
- Defined:
  - Adds output `preempt_total`, 16 bits.
  - Increments on each USER-state intr save; saturates at 16'hFFFF.
  - Cleared by reset.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then RETURN with ready_mask=0 -> ret_valid stays 0, cur_pid=0, in_kernel=1.
- Load pid1 pc=0x40 and pid2 pc=0x80, then RETURN -> next cycle ret_valid=1, ret_pc=0x40, cur_pid=1.
- In pid1, intr with PCout=0x47 -> table[1]=0x47, saved_pc=0x47, cur_pid=0, ret_valid=0.
  - Then RETURN -> ret_pc=0x80, cur_pid=2 (round-robin).
- In pid2, SYSCALL at PCout=0x85 -> table[2]=0x86, ret_pc=18, ret_valid=1.
  - Then RETURN -> ret_pc=0x47 (pid3 not ready, skip KERNEL_PID).
- In pid1, HALT and intr in the same cycle with PCout=0x50 -> intr wins: ready[1] stays 1, table[1]=0x50, ret_valid=0.
  - Then HALT alone -> ready_mask[1]=0, ret_pc=18.
- proc_load pid1 pc=0x99 in the same cycle as an intr save of pid1 at 0x60 -> table[1]=0x60.
  - Assert reset while RETURN is in flight -> ret_valid=0 and all table entries 0.
